// File: rtl/color_pkg.sv
// Shared definitions for the colour-detection front end.
//   - filter-select codes driven onto the sensor's {s2, s3} pins
//   - filter index values (order of measurement: red, blue, green)
//   - colour classification enum and FSM state type
//   - small helpers for filter-select lookup and LED slot advance
package color_pkg;

    // {s2, s3} codes for the sensor's photodiode filter selects
    localparam logic [1:0] SEL_RED   = 2'b00;
    localparam logic [1:0] SEL_BLUE  = 2'b01;
    localparam logic [1:0] SEL_GREEN = 2'b11;

    // Filter index, in measurement order
    localparam logic [1:0] FILT_RED   = 2'd0;
    localparam logic [1:0] FILT_BLUE  = 2'd1;
    localparam logic [1:0] FILT_GREEN = 2'd2;

    typedef enum logic [1:0] {
        COLOR_NONE,
        COLOR_RED,
        COLOR_BLUE,
        COLOR_GREEN
    } color_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COUNT,
        ST_DECIDE,
        ST_EMIT
    } state_e;

    function automatic logic [1:0] filter_sel(input logic [1:0] idx);
        case (idx)
            FILT_BLUE:  filter_sel = SEL_BLUE;
            FILT_GREEN: filter_sel = SEL_GREEN;
            default:    filter_sel = SEL_RED;
        endcase
    endfunction

    // LED slots cycle 1 -> 2 -> 3 -> 1; slot 0 means "nothing shown yet"
    function automatic logic [1:0] next_slot(input logic [1:0] slot);
        next_slot = (slot == 2'd3) ? 2'd1 : slot + 2'd1;
    endfunction

endpackage

// File: rtl/edge_counter.sv
// Edge counter for the colour sensor's square-wave output.
//   clk       system clock
//   rst       synchronous active-high reset (clears synchronizer and count)
//   sensor_i  raw sensor output, asynchronous to clk
//   enable_i  count detected rising edges while high
//   clear_i   zero the count (takes priority over enable_i)
//   count_o   saturating edge count
// The synchronizer and edge detector run continuously so that the edge history
// is already settled when counting is enabled.
module edge_counter
    import color_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sensor_i,
    input  logic             enable_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] count_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic             prev_q;
    logic [CNT_W-1:0] count_q;
    logic             rise;

    assign rise    = sync2_q & ~prev_q;
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            count_q <= '0;
        end else begin
            sync1_q <= sensor_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (clear_i) begin
                count_q <= '0;
            end else if (enable_i && rise && (count_q != '1)) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/color_detector.sv
// Colour classification front end for the node-colour path.
// Steps the sensor through the red, blue and green filters, counts output edges
// over a fixed window per filter, picks the dominant colour and emits a one-hot
// strobe together with the next LED slot.
//   clk, rst                     system clock, synchronous active-high reset
//   start                        classification request (sampled in IDLE only)
//   sensor_out                   sensor square wave (asynchronous)
//   s2, s3                       filter selects: red 00, blue 01, green 11
//   red_out/blue_out/green_out   one-cycle colour strobe
//   LED_num                      LED slot of the last valid colour (0 = none)
//   busy, done, no_color         status; no_color is qualified by done
//
// state  | meaning
// IDLE   | waiting for start
// SETTLE | filter just changed, let the sensor output settle
// COUNT  | counting edges for the current filter
// DECIDE | pick the winner from the three counts
// EMIT   | done pulse, strobe / no_color, LED slot update
module color_detector
    import color_pkg::*;
#(
    parameter int SETTLE_CYC = 2000,
    parameter int WINDOW_CYC = 50000,
    parameter int MIN_COUNT  = 20,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       sensor_out,
    output logic       s2,
    output logic       s3,
    output logic       red_out,
    output logic       blue_out,
    output logic       green_out,
    output logic [1:0] LED_num,
    output logic       busy,
    output logic       done,
    output logic       no_color
);

    localparam int TMAX  = (WINDOW_CYC > SETTLE_CYC) ? WINDOW_CYC : SETTLE_CYC;
    localparam int TMR_W = $clog2(TMAX) + 1;
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] WINDOW_LOAD = TMR_W'(WINDOW_CYC - 1);
    localparam logic [CNT_W-1:0] MIN_CNT     = CNT_W'(MIN_COUNT);

    state_e           state_q;
    logic [1:0]       filter_q;
    logic [TMR_W-1:0] timer_q;
    logic [CNT_W-1:0] cnt_red_q;
    logic [CNT_W-1:0] cnt_blue_q;
    logic             cap_q;
    logic             s2_q;
    logic             s3_q;
    logic             red_q;
    logic             blue_q;
    logic             green_q;
    logic [1:0]       led_q;
    logic             busy_q;
    logic             done_q;
    logic             no_color_q;

    logic             cnt_en;
    logic             cnt_clr;
    logic [CNT_W-1:0] edge_cnt;
    color_e           win_col;
    logic [CNT_W-1:0] win_cnt;
    logic             win_valid;
    logic [1:0]       sel_next;

    // Counter is zeroed on the last settle cycle so it starts each window at 0
    // while still holding the previous filter's total during the first settle
    // cycle, when that total is copied out.
    assign cnt_en  = (state_q == ST_COUNT);
    assign cnt_clr = (state_q == ST_IDLE) ||
                     ((state_q == ST_SETTLE) && (timer_q == '0));

    edge_counter #(
        .CNT_W (CNT_W)
    ) u_edge_counter (
        .clk      (clk),
        .rst      (rst),
        .sensor_i (sensor_out),
        .enable_i (cnt_en),
        .clear_i  (cnt_clr),
        .count_o  (edge_cnt)
    );

    // Green is the last filter, so during DECIDE its total is still sitting in
    // the shared counter and is read from there directly.
    always_comb begin
        win_col = COLOR_NONE;
        win_cnt = '0;
        if ((cnt_red_q >= cnt_blue_q) && (cnt_red_q >= edge_cnt)) begin
            win_col = COLOR_RED;
            win_cnt = cnt_red_q;
        end else if (cnt_blue_q >= edge_cnt) begin
            win_col = COLOR_BLUE;
            win_cnt = cnt_blue_q;
        end else begin
            win_col = COLOR_GREEN;
            win_cnt = edge_cnt;
        end
    end

    assign win_valid = (win_cnt >= MIN_CNT);
    assign sel_next  = filter_sel(filter_q + 2'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            filter_q   <= FILT_RED;
            timer_q    <= '0;
            cnt_red_q  <= '0;
            cnt_blue_q <= '0;
            cap_q      <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            red_q      <= 1'b0;
            blue_q     <= 1'b0;
            green_q    <= 1'b0;
            led_q      <= 2'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            no_color_q <= 1'b0;
        end else begin
            cap_q      <= 1'b0;
            red_q      <= 1'b0;
            blue_q     <= 1'b0;
            green_q    <= 1'b0;
            done_q     <= 1'b0;
            no_color_q <= 1'b0;

            // One cycle after a red or blue window the filter index has already
            // advanced, so it tells which total the counter is holding.
            if (cap_q) begin
                if (filter_q == FILT_BLUE) begin
                    cnt_red_q <= edge_cnt;
                end else begin
                    cnt_blue_q <= edge_cnt;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q      <= ST_SETTLE;
                        filter_q     <= FILT_RED;
                        {s2_q, s3_q} <= SEL_RED;
                        timer_q      <= SETTLE_LOAD;
                        cnt_red_q    <= '0;
                        cnt_blue_q   <= '0;
                        busy_q       <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (timer_q == '0) begin
                        state_q <= ST_COUNT;
                        timer_q <= WINDOW_LOAD;
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end
                ST_COUNT: begin
                    if (timer_q == '0) begin
                        if (filter_q == FILT_GREEN) begin
                            state_q <= ST_DECIDE;
                        end else begin
                            state_q      <= ST_SETTLE;
                            filter_q     <= filter_q + 2'd1;
                            {s2_q, s3_q} <= sel_next;
                            timer_q      <= SETTLE_LOAD;
                            cap_q        <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end
                ST_DECIDE: begin
                    state_q <= ST_EMIT;
                    done_q  <= 1'b1;
                    if (win_valid) begin
                        led_q <= next_slot(led_q);
                        case (win_col)
                            COLOR_RED:   red_q   <= 1'b1;
                            COLOR_BLUE:  blue_q  <= 1'b1;
                            COLOR_GREEN: green_q <= 1'b1;
                            default:     ;
                        endcase
                    end else begin
                        no_color_q <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign s2        = s2_q;
    assign s3        = s3_q;
    assign red_out   = red_q;
    assign blue_out  = blue_q;
    assign green_out = green_q;
    assign LED_num   = led_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign no_color  = no_color_q;

endmodule

// File: tb/tb_color_detector.sv
// Directed bench for color_detector. The sensor waveform is generated from a
// per-filter schedule (edge count, period, optional extra edge) positioned
// relative to each filter's counting window; expected colours, LED slots and
// latencies are hand-derived per vector.
module tb_color_detector;

    localparam int S    = 4;
    localparam int W    = 100;
    localparam int MINC = 5;
    localparam int CW   = 8;
    localparam int CW2  = 4;
    localparam int LAT  = 3 * (S + W) + 2;   // start-sampling edge to done cycle

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic sensor;
    logic use2;
    logic start1, start2;

    assign start1 = start & ~use2;
    assign start2 = start & use2;

    logic       d1_s2, d1_s3, d1_r, d1_b, d1_g, d1_busy, d1_done, d1_nc;
    logic [1:0] d1_led;
    logic       d2_s2, d2_s3, d2_r, d2_b, d2_g, d2_busy, d2_done, d2_nc;
    logic [1:0] d2_led;

    color_detector #(.SETTLE_CYC(S), .WINDOW_CYC(W), .MIN_COUNT(MINC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start1), .sensor_out(sensor),
        .s2(d1_s2), .s3(d1_s3), .red_out(d1_r), .blue_out(d1_b), .green_out(d1_g),
        .LED_num(d1_led), .busy(d1_busy), .done(d1_done), .no_color(d1_nc));

    color_detector #(.SETTLE_CYC(S), .WINDOW_CYC(W), .MIN_COUNT(MINC), .CNT_W(CW2)) dut_sat (
        .clk(clk), .rst(rst), .start(start2), .sensor_out(sensor),
        .s2(d2_s2), .s3(d2_s3), .red_out(d2_r), .blue_out(d2_b), .green_out(d2_g),
        .LED_num(d2_led), .busy(d2_busy), .done(d2_done), .no_color(d2_nc));

    logic       o_s2, o_s3, o_r, o_b, o_g, o_busy, o_done, o_nc;
    logic [1:0] o_led;

    always_comb begin
        if (use2) begin
            {o_s2, o_s3, o_r, o_b, o_g, o_busy, o_done, o_nc} =
                {d2_s2, d2_s3, d2_r, d2_b, d2_g, d2_busy, d2_done, d2_nc};
            o_led = d2_led;
        end else begin
            {o_s2, o_s3, o_r, o_b, o_g, o_busy, o_done, o_nc} =
                {d1_s2, d1_s3, d1_r, d1_b, d1_g, d1_busy, d1_done, d1_nc};
            o_led = d1_led;
        end
    end

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int m1 = 0;   // expected LED slot, main instance
    int m2 = 0;   // expected LED slot, 4-bit counter instance

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Sensor schedule, per filter: n edges of period p starting at window
    // offset 5, an optional single extra edge at offset x, and an optional
    // one-cycle glitch on the first settle cycle that must not be counted.
    int n_a[3];
    int p_a[3];
    int x_a[3];
    bit noise_a;

    function automatic int c0(input int i);
        return 1 + i * (S + W) + S;
    endfunction

    function automatic bit sched(input int t);
        bit v;
        int o;
        int hi;
        v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            o = t - c0(i);
            if (o >= -S && o < W) begin
                if (noise_a && o == -S) v = 1'b1;
                if (n_a[i] > 0 && o >= 5 && o < 5 + n_a[i] * p_a[i]) begin
                    hi = (p_a[i] / 2 > 0) ? p_a[i] / 2 : 1;
                    if (((o - 5) % p_a[i]) < hi) v = 1'b1;
                end
                if (x_a[i] >= 0 && o == x_a[i]) v = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic int sel_exp(input int i);
        if (i == 0) return 0;
        if (i == 1) return 1;
        return 3;
    endfunction

    function automatic int nslot(input int m);
        return (m == 3) ? 1 : m + 1;
    endfunction

    typedef struct {
        int nr; int pr; int xr;
        int nb; int pb; int xb;
        int ng; int pg; int xg;
        bit noise;
        int exp_col;   // 0 none, 1 red, 2 blue, 3 green
        bit dut2;
    } vec_t;

    vec_t vecs[$];

    task automatic set_sched(input vec_t v);
        n_a[0] = v.nr; p_a[0] = v.pr; x_a[0] = v.xr;
        n_a[1] = v.nb; p_a[1] = v.pb; x_a[1] = v.xb;
        n_a[2] = v.ng; p_a[2] = v.pg; x_a[2] = v.xg;
        noise_a = v.noise;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int first_done, led_at, nc_at, sr, sb, sg, busy_bad, busy_after, sel_bad;
        int m, exp_led;
        first_done = -1; led_at = -1; nc_at = -1;
        sr = 0; sb = 0; sg = 0; busy_bad = 0; busy_after = -1; sel_bad = 0;
        use2 = v.dut2;
        set_sched(v);
        m = v.dut2 ? m2 : m1;
        exp_led = (v.exp_col != 0) ? nslot(m) : m;

        @(negedge clk);
        sensor = 1'b0;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int t = 1; t <= LAT + 2; t++) begin
            sensor = sched(t);
            if (o_done) begin
                if (first_done < 0) first_done = t;
                led_at = int'(o_led);
                nc_at  = int'(o_nc);
            end
            sr += int'(o_r);
            sb += int'(o_b);
            sg += int'(o_g);
            if (t <= LAT && !o_busy) busy_bad++;
            if (t == LAT + 1) busy_after = int'(o_busy);
            for (int i = 0; i < 3; i++)
                if (t == c0(i) && int'({o_s2, o_s3}) != sel_exp(i)) sel_bad++;
            @(posedge clk);
            @(negedge clk);
        end
        sensor = 1'b0;

        check({tag, "_done_cycle"}, first_done, LAT);
        check({tag, "_led"}, led_at, exp_led);
        check({tag, "_no_color"}, nc_at, (v.exp_col == 0) ? 1 : 0);
        check({tag, "_red_strobes"}, sr, (v.exp_col == 1) ? 1 : 0);
        check({tag, "_blue_strobes"}, sb, (v.exp_col == 2) ? 1 : 0);
        check({tag, "_green_strobes"}, sg, (v.exp_col == 3) ? 1 : 0);
        check({tag, "_busy_gaps"}, busy_bad, 0);
        check({tag, "_busy_after"}, busy_after, 0);
        check({tag, "_filter_sel"}, sel_bad, 0);

        if (v.dut2) m2 = exp_led;
        else        m1 = exp_led;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone, t1, t2, sr, sb, sg, nnc, busy_bad, led_now, busy_after;
        vec_t quiet;

        rst = 1'b1; start = 1'b0; sensor = 1'b0; use2 = 1'b0;
        for (int i = 0; i < 3; i++) begin n_a[i] = 0; p_a[i] = 4; x_a[i] = -1; end
        noise_a = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_outputs_main",
              int'({d1_s2, d1_s3, d1_r, d1_b, d1_g, d1_led, d1_busy, d1_done, d1_nc}), 0);
        check("reset_outputs_sat",
              int'({d2_s2, d2_s3, d2_r, d2_b, d2_g, d2_led, d2_busy, d2_done, d2_nc}), 0);

        //              nr pr  xr  nb pb  xb  ng pg  xg noise col dut2
        vecs.push_back('{ 3,10, -1,  6, 8, -1, 15, 4, -1, 1'b1, 3, 1'b0}); // green, slot 1
        vecs.push_back('{ 8, 6, -1,  2,10, -1, 12, 4, -1, 1'b1, 3, 1'b0}); // green, slot 2
        vecs.push_back('{ 0, 4, -1,  0, 4, -1,  5, 4, -1, 1'b1, 3, 1'b0}); // green at threshold, slot 3
        vecs.push_back('{10, 4, -1, 10, 4, -1, 11, 4, -1, 1'b1, 3, 1'b0}); // green, slot wraps to 1
        vecs.push_back('{20, 4, -1,  4,20, -1,  4,20, -1, 1'b1, 1, 1'b0}); // red dominant
        vecs.push_back('{ 0, 4, -1,  0, 4, -1,  0, 4, -1, 1'b0, 0, 1'b0}); // static low
        vecs.push_back('{ 4, 4, -1,  2, 4, -1,  3, 4, -1, 1'b1, 0, 1'b0}); // below threshold
        vecs.push_back('{ 0, 4, -1,  5, 4, -1,  4, 4, -1, 1'b1, 2, 1'b0}); // blue at threshold
        vecs.push_back('{25, 3, -1, 25, 3, -1, 10, 4, -1, 1'b1, 1, 1'b0}); // red/blue tie
        vecs.push_back('{ 3, 4, -1, 12, 4, -1, 12, 4, -1, 1'b1, 2, 1'b0}); // blue/green tie
        vecs.push_back('{ 6, 4, W-2, 6, 4, W-3, 0, 4, -1, 1'b1, 2, 1'b0}); // window edge boundary
        vecs.push_back('{10, 4, -1, 40, 2, -1, 10, 4, -1, 1'b1, 2, 1'b1}); // blue saturates at 15

        for (int k = 0; k < vecs.size(); k++)
            run_vec(vecs[k], $sformatf("v%0d", k));

        // start held high: one classification per IDLE visit
        use2 = 1'b0;
        quiet = '{0, 4, -1, 0, 4, -1, 0, 4, -1, 1'b0, 0, 1'b0};
        set_sched(quiet);
        ndone = 0; t1 = -1; t2 = -1; sr = 0; sb = 0; sg = 0; nnc = 0; busy_after = -1;
        led_now = m1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int t = 1; t <= 2 * LAT + 3; t++) begin
            if (t == 2 * LAT + 2) start = 1'b0;
            if (o_done) begin
                ndone++;
                if (ndone == 1) t1 = t;
                if (ndone == 2) t2 = t;
            end
            nnc += int'(o_nc);
            sr += int'(o_r); sb += int'(o_b); sg += int'(o_g);
            if (t == 2 * LAT + 3) busy_after = int'(o_busy);
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        check("hold_done_count", ndone, 2);
        check("hold_first_done", t1, LAT);
        check("hold_second_done", t2, 2 * LAT + 1);
        check("hold_no_color_count", nnc, 2);
        check("hold_strobes", sr + sb + sg, 0);
        check("hold_busy_after_release", busy_after, 0);
        check("hold_led_unchanged", int'(o_led), led_now);

        // start pulsed mid-COUNT and again in the done cycle: both ignored
        ndone = 0; t1 = -1; busy_bad = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int t = 1; t <= LAT + 20; t++) begin
            start = (t == 150 || t == LAT) ? 1'b1 : 1'b0;
            if (o_done) begin
                ndone++;
                if (ndone == 1) t1 = t;
            end
            if (t > LAT && o_busy) busy_bad++;
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        check("ignore_done_count", ndone, 1);
        check("ignore_done_cycle", t1, LAT);
        check("ignore_no_rerun", busy_bad, 0);

        // reset during the second (blue) COUNT phase
        check("pre_reset_led_nonzero", (m1 != 0) ? 1 : 0, 1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int t = 1; t < c0(1) + 30; t++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("mid_run_busy", int'(o_busy), 1);
        check("mid_run_blue_sel", int'({o_s2, o_s3}), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_outputs_main",
              int'({d1_s2, d1_s3, d1_r, d1_b, d1_g, d1_led, d1_busy, d1_done, d1_nc}), 0);
        check("midrst_outputs_sat",
              int'({d2_s2, d2_s3, d2_r, d2_b, d2_g, d2_led, d2_busy, d2_done, d2_nc}), 0);
        m1 = 0;
        m2 = 0;
        run_vec('{20, 4, -1, 4, 20, -1, 4, 20, -1, 1'b1, 1, 1'b0}, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
